// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss stopwatch: FSM states, BCD digit
// width, per-digit roll-over limits and a small BCD conversion helper.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] SEC_ONES_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] MIN_ONES_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] MIN_TENS_MAX = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Splits a 0..99 integer into two packed BCD digits {tens, ones}.
    function automatic logic [2*DIGIT_W-1:0] to_bcd2(input int value);
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
        tens = DIGIT_W'(value / 10);
        ones = DIGIT_W'(value % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control pulses in and display/status out of the stopwatch counter;
// master drives the pulses, slave (the counter) drives the display.
interface stopwatch_counter_if;

    logic        tick;
    logic        start;
    logic        clr;
    logic        lap;
    logic [15:0] disp;
    logic        running;
    logic        wrap;
    logic        frozen;

    modport master (
        output tick, start, clr, lap,
        input  disp, running, wrap, frozen
    );

    modport slave (
        input  tick, start, clr, lap,
        output disp, running, wrap, frozen
    );

endinterface

// File: rtl/bcd_digit.sv
// One modulo-(MAX+1) BCD digit; exposes both the registered value and the
// value it will take on the next edge so the parent can register a display.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = SEC_ONES_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic [DIGIT_W-1:0] nxt,
    output logic               carry
);

    assign carry = inc && (q == MAX);

    always_comb begin
        nxt = q;
        if (clear) begin
            nxt = '0;
        end else if (inc) begin
            nxt = (q == MAX) ? '0 : q + DIGIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// BCD mm:ss stopwatch with IDLE/RUN/PAUSE control and registered outputs.
// Define STOPWATCH_LAP_EN to compile in the lap-hold display feature.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX = 59
) (
    input logic                clk,
    input logic                rst,
    stopwatch_counter_if.slave bus
);

    localparam logic [2*DIGIT_W-1:0] MIN_LIM = to_bcd2(MIN_MAX);

    state_t                        state_q;
    state_t                        state_d;
    logic                          count_en;
    logic                          at_max;
    logic                          clear;
    logic [3:0][DIGIT_W-1:0]       cnt_q;
    logic [3:0][DIGIT_W-1:0]       cnt_nxt;
    logic [2:0]                    carry;
    logic                          unused_carry;
    logic [4*DIGIT_W-1:0]          disp_q;
    logic                          running_q;
    logic                          wrap_q;
    logic                          frozen_q;
    logic                          frozen_d;

    always_comb begin
        state_d  = state_q;
        count_en = 1'b0;
        if (bus.clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start) state_d = RUN;
                RUN: begin
                    count_en = bus.tick;
                    if (bus.start) state_d = PAUSE;
                end
                PAUSE:   if (bus.start) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Roll-over point is MIN_MAX:59, which need not coincide with the digit limits.
    assign at_max = (cnt_q[3] == MIN_LIM[2*DIGIT_W-1:DIGIT_W]) &&
                    (cnt_q[2] == MIN_LIM[DIGIT_W-1:0]) &&
                    (cnt_q[1] == SEC_TENS_MAX) &&
                    (cnt_q[0] == SEC_ONES_MAX);
    assign clear  = bus.clr || (count_en && at_max);

    bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .clear(clear), .inc(count_en),
        .q(cnt_q[0]), .nxt(cnt_nxt[0]), .carry(carry[0])
    );
    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .clear(clear), .inc(carry[0]),
        .q(cnt_q[1]), .nxt(cnt_nxt[1]), .carry(carry[1])
    );
    bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .clear(clear), .inc(carry[1]),
        .q(cnt_q[2]), .nxt(cnt_nxt[2]), .carry(carry[2])
    );
    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .clear(clear), .inc(carry[2]),
        .q(cnt_q[3]), .nxt(cnt_nxt[3]), .carry(unused_carry)
    );

`ifdef STOPWATCH_LAP_EN
    // Lap toggles the hold only while running; clr always releases it.
    always_comb begin
        frozen_d = frozen_q;
        if (bus.clr) begin
            frozen_d = 1'b0;
        end else if (bus.lap && (state_q == RUN)) begin
            frozen_d = !frozen_q;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = bus.lap;
    assign frozen_d   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            frozen_q  <= 1'b0;
            disp_q    <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUN);
            wrap_q    <= count_en && at_max;
            frozen_q  <= frozen_d;
            disp_q    <= frozen_d ? disp_q : cnt_nxt;
        end
    end

    assign bus.disp    = disp_q;
    assign bus.running = running_q;
    assign bus.wrap    = wrap_q;
    assign bus.frozen  = frozen_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: a vector table for single-cycle
// behaviour plus hand-written sequences for roll-over, wrap, lap and reset.
module tb_stopwatch_counter;

    logic clk;
    logic rst;
    int   vec_count;
    int   miscompares;

    stopwatch_counter_if sw_if ();

    stopwatch_counter #(.MIN_MAX(59)) dut (
        .clk(clk),
        .rst(rst),
        .bus(sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tick;
        logic        start;
        logic        clr;
        logic        lap;
        logic [15:0] disp;
        logic        running;
        logic        wrap;
        logic        frozen;
    } vec_t;

    vec_t vecs [16];

    // One clock cycle of input pulses, leaving the bench just after the edge.
    task automatic applyStimulus(input logic t, input logic s, input logic c, input logic l);
        @(negedge clk);
        sw_if.tick  = t;
        sw_if.start = s;
        sw_if.clr   = c;
        sw_if.lap   = l;
        @(posedge clk);
        #1;
        sw_if.tick  = 1'b0;
        sw_if.start = 1'b0;
        sw_if.clr   = 1'b0;
        sw_if.lap   = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] e_disp,
                               input logic e_run, input logic e_wrap, input logic e_frozen);
        vec_count++;
        if (sw_if.disp !== e_disp || sw_if.running !== e_run ||
            sw_if.wrap !== e_wrap || sw_if.frozen !== e_frozen) begin
            miscompares++;
            $display("[TB] FAIL %s: got disp=%h running=%b wrap=%b frozen=%b, want disp=%h running=%b wrap=%b frozen=%b",
                     name, sw_if.disp, sw_if.running, sw_if.wrap, sw_if.frozen,
                     e_disp, e_run, e_wrap, e_frozen);
        end
    endtask

    task automatic runTicks(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vec_count   = 0;
        miscompares = 0;
        sw_if.tick  = 1'b0;
        sw_if.start = 1'b0;
        sw_if.clr   = 1'b0;
        sw_if.lap   = 1'b0;
        rst         = 1'b0;

        //            tick  start clr   lap   disp      run   wrap  frz
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0006, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};

        #2;
        checkOutput("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_exit", 16'h0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].tick, vecs[i].start, vecs[i].clr, vecs[i].lap);
            checkOutput($sformatf("vec%0d", i), vecs[i].disp, vecs[i].running,
                        vecs[i].wrap, vecs[i].frozen);
        end

        // Digit carries and the full 59:59 wrap, counted up from zero.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        runTicks(59);
        checkOutput("at_0059", 16'h0059, 1'b1, 1'b0, 1'b0);
        runTicks(1);
        checkOutput("carry_0100", 16'h0100, 1'b1, 1'b0, 1'b0);
        runTicks(539);
        checkOutput("at_0959", 16'h0959, 1'b1, 1'b0, 1'b0);
        runTicks(1);
        checkOutput("carry_1000", 16'h1000, 1'b1, 1'b0, 1'b0);
        runTicks(2999);
        checkOutput("at_5959", 16'h5959, 1'b1, 1'b0, 1'b0);
        runTicks(1);
        checkOutput("wrap_pulse", 16'h0000, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_drop", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Simultaneous tick and start while running.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        runTicks(10);
        checkOutput("at_0010", 16'h0010, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("tick_start", 16'h0011, 1'b0, 1'b0, 1'b0);
        runTicks(3);
        checkOutput("pause_ticks", 16'h0011, 1'b0, 1'b0, 1'b0);

        // clr beats start and tick in the same cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        runTicks(31);
        checkOutput("at_0042", 16'h0042, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("clr_priority", 16'h0000, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        runTicks(7);
        checkOutput("at_0007", 16'h0007, 1'b1, 1'b0, 1'b0);
`ifdef STOPWATCH_LAP_EN
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lap_capture", 16'h0007, 1'b1, 1'b0, 1'b1);
        runTicks(4);
        checkOutput("lap_hold", 16'h0007, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lap_release", 16'h0011, 1'b1, 1'b0, 1'b0);
        runTicks(19);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lap_at_0030", 16'h0030, 1'b1, 1'b0, 1'b1);
`else
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lap_ignored", 16'h0007, 1'b1, 1'b0, 1'b0);
        runTicks(4);
        checkOutput("lap_live", 16'h0011, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lap_ignored2", 16'h0011, 1'b1, 1'b0, 1'b0);
        runTicks(19);
        checkOutput("at_0030", 16'h0030, 1'b1, 1'b0, 1'b0);
`endif

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("post_reset_tick", 16'h0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("post_reset_start", 16'h0000, 1'b1, 1'b0, 1'b0);
        runTicks(1);
        checkOutput("post_reset_count", 16'h0001, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
